// File: rtl/lv2_mem_responder.sv
// lv2_mem_responder: word-addressed main-memory model answering L2 mem_rd/mem_wr with fixed latencies.
// Optional feature macro MEM_PROT_CHK_EN adds the sticky proto_err output for handshake violations.
module lv2_mem_responder #(
  parameter int DATA_WID   = 32,
  parameter int ADDR_WID   = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int RD_LATENCY = 4,
  parameter int WR_LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_WID-1:0] addr_bus_lv2_mem,
  inout  wire  [DATA_WID-1:0] data_bus_lv2_mem,
  input  logic                mem_rd,
  input  logic                mem_wr,
  output logic                mem_wr_done,
`ifdef MEM_PROT_CHK_EN
  output logic                proto_err,
`endif
  output logic                data_in_bus_lv2_mem
);

  localparam int IDX_WID = $clog2(MEM_DEPTH);
  localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int CNT_WID = $clog2(MAX_LAT + 1);
  localparam logic [CNT_WID-1:0] RD_LOAD = CNT_WID'(RD_LATENCY - 1);
  localparam logic [CNT_WID-1:0] WR_LOAD = CNT_WID'(WR_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    RD_DRIVE = 3'd2,
    WR_WAIT  = 3'd3,
    WR_DONE  = 3'd4
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic [DATA_WID-1:0]  mem_r [MEM_DEPTH];
  logic [MEM_DEPTH-1:0] vld_r;
  logic [IDX_WID-1:0]   idx_r;
  logic [DATA_WID-1:0]  wr_data_r;
  logic [DATA_WID-1:0]  rd_data_r;
  logic [CNT_WID-1:0]   cnt_r;
  logic                 cnt_zero_s;
  logic [IDX_WID-1:0]   req_idx_s;
  logic                 accept_rd_s;
  logic                 accept_wr_s;
  logic                 rd_load_s;
  logic                 wr_commit_s;
  logic                 dec_s;
  logic                 rd_valid_s;
  logic                 wr_done_s;
  logic                 unused_addr_s;

  // Upper address bits are deliberately dropped so out-of-range addresses wrap.
  assign req_idx_s     = addr_bus_lv2_mem[IDX_WID-1:0];
  assign unused_addr_s = ^addr_bus_lv2_mem[ADDR_WID-1:IDX_WID];
  assign cnt_zero_s    = (cnt_r == {CNT_WID{1'b0}});

  // The bus is released whenever read data is not being presented.
  assign data_bus_lv2_mem = data_in_bus_lv2_mem ? rd_data_r : {DATA_WID{1'bz}};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; an early mem_rd drop in RD_WAIT wins over counter expiry.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (mem_rd && !mem_wr) begin
          state_s = RD_WAIT;
        end else if (mem_wr && !mem_rd) begin
          state_s = WR_WAIT;
        end else begin
          state_s = IDLE;
        end
      end
      RD_WAIT: begin
        if (!mem_rd) begin
          state_s = IDLE;
        end else if (cnt_zero_s) begin
          state_s = RD_DRIVE;
        end else begin
          state_s = RD_WAIT;
        end
      end
      RD_DRIVE: begin
        if (!mem_rd) begin
          state_s = IDLE;
        end else begin
          state_s = RD_DRIVE;
        end
      end
      WR_WAIT: begin
        if (cnt_zero_s) begin
          state_s = WR_DONE;
        end else begin
          state_s = WR_WAIT;
        end
      end
      WR_DONE: begin
        if (!mem_wr) begin
          state_s = IDLE;
        end else begin
          state_s = WR_DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Datapath strobes and the next values of the registered handshake outputs.
  always_comb begin
    accept_rd_s = 1'b0;
    accept_wr_s = 1'b0;
    rd_load_s   = 1'b0;
    wr_commit_s = 1'b0;
    dec_s       = 1'b0;
    case (state_r)
      IDLE: begin
        accept_rd_s = mem_rd & ~mem_wr;
        accept_wr_s = mem_wr & ~mem_rd;
      end
      RD_WAIT: begin
        rd_load_s = mem_rd & cnt_zero_s;
        dec_s     = ~cnt_zero_s;
      end
      WR_WAIT: begin
        wr_commit_s = cnt_zero_s;
        dec_s       = ~cnt_zero_s;
      end
      default: begin
        dec_s = 1'b0;
      end
    endcase
    rd_valid_s = (state_s == RD_DRIVE);
    wr_done_s  = (state_s == WR_DONE);
  end

  // Registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wr_done         <= 1'b0;
      data_in_bus_lv2_mem <= 1'b0;
    end else begin
      mem_wr_done         <= wr_done_s;
      data_in_bus_lv2_mem <= rd_valid_s;
    end
  end

  // Request capture, latency counter, read register and per-word written flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r     <= {IDX_WID{1'b0}};
      wr_data_r <= {DATA_WID{1'b0}};
      rd_data_r <= {DATA_WID{1'b0}};
      cnt_r     <= {CNT_WID{1'b0}};
      vld_r     <= {MEM_DEPTH{1'b0}};
    end else begin
      if (accept_rd_s || accept_wr_s) begin
        idx_r <= req_idx_s;
      end
      if (accept_wr_s) begin
        wr_data_r <= data_bus_lv2_mem;
      end
      if (accept_rd_s) begin
        cnt_r <= RD_LOAD;
      end else if (accept_wr_s) begin
        cnt_r <= WR_LOAD;
      end else if (dec_s) begin
        cnt_r <= cnt_r - CNT_WID'(1'b1);
      end
      // A word never written since reset reads as zero, which is how the array clears on reset.
      if (rd_load_s) begin
        rd_data_r <= vld_r[idx_r] ? mem_r[idx_r] : {DATA_WID{1'b0}};
      end
      if (wr_commit_s) begin
        vld_r[idx_r] <= 1'b1;
      end
    end
  end

  // Backing store write port.
  always_ff @(posedge clk) begin
    if (wr_commit_s) begin
      mem_r[idx_r] <= wr_data_r;
    end
  end

`ifdef MEM_PROT_CHK_EN
  logic proto_hit_s;

  // Handshake violations seen in the current state.
  always_comb begin
    proto_hit_s = 1'b0;
    case (state_r)
      IDLE:     proto_hit_s = mem_rd & mem_wr;
      RD_WAIT:  proto_hit_s = ~mem_rd | mem_wr;
      RD_DRIVE: proto_hit_s = mem_wr;
      WR_WAIT:  proto_hit_s = mem_rd;
      WR_DONE:  proto_hit_s = mem_rd;
      default:  proto_hit_s = 1'b0;
    endcase
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proto_err <= 1'b0;
    end else if (proto_hit_s) begin
      proto_err <= 1'b1;
    end else begin
      proto_err <= proto_err;
    end
  end
`endif

endmodule

// File: tb/tb_lv2_mem_responder.sv
// Scoreboard bench for lv2_mem_responder: directed scenarios followed by randomized traffic
// checked against a flat word-array memory model.
module tb_lv2_mem_responder;

  localparam int RD_LAT = 4;
  localparam int WR_LAT = 2;
  localparam int DEPTH  = 1024;

  typedef struct {
    bit          is_rd;
    logic [31:0] data;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic        mem_rd;
  logic        mem_wr;
  logic        mem_wr_done;
  logic        data_in_bus;
  logic        tb_drv_en;
  logic [31:0] tb_drv_data;
  wire  [31:0] data_bus;
`ifdef MEM_PROT_CHK_EN
  logic        proto_err;
`endif

  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;
  exp_t        exp_q[$];
  logic [31:0] model [DEPTH];

  assign data_bus = tb_drv_en ? tb_drv_data : 32'hzzzz_zzzz;

  lv2_mem_responder #(
    .DATA_WID(32), .ADDR_WID(32), .MEM_DEPTH(DEPTH),
    .RD_LATENCY(RD_LAT), .WR_LATENCY(WR_LAT)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .addr_bus_lv2_mem    (addr),
    .data_bus_lv2_mem    (data_bus),
    .mem_rd              (mem_rd),
    .mem_wr              (mem_wr),
    .mem_wr_done         (mem_wr_done),
`ifdef MEM_PROT_CHK_EN
    .proto_err           (proto_err),
`endif
    .data_in_bus_lv2_mem (data_in_bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    r[9:0] = 10'($urandom_range(0, 15));
    return r;
  endfunction

  // All tasks start and end 1ns after a rising edge; the request is sampled at the next edge.
  task automatic do_read(input logic [31:0] a, input int extra);
    int w;
    addr = a;
    mem_rd = 1'b1;
    exp_q.push_back('{1'b1, model[a % DEPTH], cyc + 1 + RD_LAT});
    w = 0;
    while (data_in_bus !== 1'b1 && w < RD_LAT + 8) begin
      tick();
      w++;
    end
    chk("rd_timeout", {31'b0, data_in_bus}, 32'd1);
    repeat (extra) tick();
    mem_rd = 1'b0;
    tick();
    chk("rd_release", {31'b0, data_in_bus}, 32'd0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int extra);
    int w;
    addr = a;
    tb_drv_data = d;
    tb_drv_en = 1'b1;
    mem_wr = 1'b1;
    exp_q.push_back('{1'b0, d, cyc + 1 + WR_LAT});
    model[a % DEPTH] = d;
    tick();
    tb_drv_en = 1'b0;
    w = 0;
    while (mem_wr_done !== 1'b1 && w < WR_LAT + 8) begin
      tick();
      w++;
    end
    chk("wr_timeout", {31'b0, mem_wr_done}, 32'd1);
    repeat (extra) tick();
    mem_wr = 1'b0;
    tick();
    chk("wr_release", {31'b0, mem_wr_done}, 32'd0);
  endtask

  task automatic do_abort(input logic [31:0] a, input int h);
    addr = a;
    mem_rd = 1'b1;
    repeat (h) tick();
    mem_rd = 1'b0;
    repeat (RD_LAT + 2) tick();
    chk("abort_no_data", {31'b0, data_in_bus}, 32'd0);
  endtask

  task automatic do_both(input int n);
    addr = rand_addr();
    mem_rd = 1'b1;
    mem_wr = 1'b1;
    repeat (n) tick();
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    repeat (RD_LAT + 2) tick();
    chk("both_no_resp", {30'b0, data_in_bus, mem_wr_done}, 32'd0);
  endtask

  task automatic do_reset_write(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    tb_drv_data = d;
    tb_drv_en = 1'b1;
    mem_wr = 1'b1;
    tick();
    rst_n = 1'b0;
    mem_wr = 1'b0;
    tb_drv_en = 1'b0;
    #1;
    chk("rst_outputs", {30'b0, data_in_bus, mem_wr_done}, 32'd0);
`ifdef MEM_PROT_CHK_EN
    chk("rst_proto_err", {31'b0, proto_err}, 32'd0);
`endif
    tick();
    rst_n = 1'b1;
    model_clear();
    tick();
  endtask

  // Monitor: pops the scoreboard whenever a handshake output rises.
  initial begin
    logic prev_rd;
    logic prev_wd;
    logic [31:0] hold_data;
    exp_t e;
    prev_rd = 1'b0;
    prev_wd = 1'b0;
    hold_data = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_wr_done === 1'b1 && data_in_bus === 1'b1) begin
        chk("excl_outputs", {30'b0, data_in_bus, mem_wr_done}, 32'd1);
      end
      if (data_in_bus === 1'b1 && !prev_rd) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rd", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rd_kind", {31'b0, e.is_rd}, 32'd1);
          chk("rd_latency", cyc, e.cyc);
          chk("rd_data", data_bus, e.data);
          hold_data = e.data;
        end
      end else if (data_in_bus === 1'b1) begin
        chk("rd_hold", data_bus, hold_data);
      end
      if (mem_wr_done === 1'b1 && !prev_wd) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_wr", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_kind", {31'b0, e.is_rd}, 32'd0);
          chk("wr_latency", cyc, e.cyc);
        end
      end
      prev_rd = (data_in_bus === 1'b1);
      prev_wd = (mem_wr_done === 1'b1);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int op;
    logic [31:0] a;
    rst_n = 1'b0;
    addr = 32'h0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    tb_drv_en = 1'b0;
    tb_drv_data = 32'h0;
    model_clear();
    repeat (2) tick();
    chk("reset_outputs", {30'b0, data_in_bus, mem_wr_done}, 32'd0);
    rst_n = 1'b1;
    tick();
`ifdef MEM_PROT_CHK_EN
    chk("reset_proto_err", {31'b0, proto_err}, 32'd0);
`endif

    do_read(32'h10, 1);
    do_write(32'h20, 32'hDEAD_BEEF, 0);
    do_read(32'h20, 0);
    do_write(32'h5, 32'h1234_5678, 1);
    do_read(32'h405, 0);
    do_both(2);
`ifdef MEM_PROT_CHK_EN
    chk("proto_err_both", {31'b0, proto_err}, 32'd1);
`endif
    do_abort(32'h20, 2);
    do_read(32'h5, 0);
    do_reset_write(32'h30, 32'hCAFE_F00D);
    do_read(32'h30, 0);
    do_read(32'h20, 0);

    for (int i = 0; i < 160; i++) begin
      op = $urandom_range(0, 19);
      a = rand_addr();
      if (op < 8) begin
        do_read(a, $urandom_range(0, 2));
      end else if (op < 16) begin
        do_write(a, $urandom, $urandom_range(0, 2));
      end else if (op < 18) begin
        do_abort(a, $urandom_range(1, RD_LAT - 1));
      end else if (op == 18) begin
        do_both($urandom_range(1, 3));
      end else begin
        do_reset_write(a, $urandom);
      end
      repeat ($urandom_range(0, 1)) tick();
    end

    repeat (4) tick();
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lv2_mem_responder.md
# lv2_mem_responder

Main-memory responder for the level-2 to memory interface of the two-level MESI cache hierarchy. It sits below the L2 cache and answers its `mem_rd` / `mem_wr` requests. It services them with configurable read and write latencies, holding a word-addressed backing store and driving the shared tri-state data bus only while returning read data. It is the synthesizable memory model used by system-level cache-coherence benches in place of a behavioural memory.

## Interface
Parameters:
- `DATA_WID`, 32, width of `data_bus_lv2_mem` and of each stored word.
- `ADDR_WID`, 32, width of `addr_bus_lv2_mem`.
- `MEM_DEPTH`, 1024, number of stored words; power of two.
- `RD_LATENCY`, 4, cycles from the read request edge to read data valid; legal range ≥ 1.
- `WR_LATENCY`, 2, cycles from the write request edge to write completion; legal range ≥ 1.

Ports:
- `clk`, input, 1, single clock; all logic is rising-edge.
- `rst_n`, input, 1, asynchronous active-low reset.
- `addr_bus_lv2_mem`, input, `ADDR_WID`, word address from L2.
- `data_bus_lv2_mem`, inout, `DATA_WID`:
  - L2 drives write data on this bus.
  - This block drives read data on it only in `RD_DRIVE`; it is `'z` at all other times.
- `mem_rd`, input, 1, read request; level, held by L2 until data is accepted.
- `mem_wr`, input, 1, write request; level, held by L2 until `mem_wr_done` is seen.
- `mem_wr_done`, output, 1, write complete.
- `data_in_bus_lv2_mem`, output, 1, read data valid on `data_bus_lv2_mem`.
- `proto_err`, output, 1, sticky protocol-error flag; this port exists only with `MEM_PROT_CHK_EN`.

## Operation
- Index is `addr_bus_lv2_mem[$clog2(MEM_DEPTH)-1:0]`. Upper address bits are ignored, so out-of-range addresses wrap.
- The FSM has five states: `IDLE`, `RD_WAIT`, `RD_DRIVE`, `WR_WAIT`, `WR_DONE`.
- Latency counter width is `$clog2(max(RD_LATENCY,WR_LATENCY)+1)`. The counter loads the relevant latency minus 1 on request acceptance and decrements to 0.
- From `IDLE`:
  - `mem_rd`=1 and `mem_wr`=0: latch the index, go to `RD_WAIT`.
  - `mem_wr`=1 and `mem_rd`=0: latch the index and the bus data, go to `WR_WAIT`.
  - Both high: protocol error; no request is accepted and the FSM stays in `IDLE`.
- `RD_WAIT`:
  - Counter reaches 0: load the read register from the array, go to `RD_DRIVE`.
  - `mem_rd` drops early: abort to `IDLE`; no data is driven.
- `RD_DRIVE`:
  - Drive the read register onto the bus and assert `data_in_bus_lv2_mem`.
  - When `mem_rd`=0 is sampled, release the bus, deassert, and go to `IDLE`.
- `WR_WAIT`: when the counter reaches 0, write the latched data to the array and go to `WR_DONE`. A write that has been accepted always completes, even if `mem_wr` drops.
- `WR_DONE`: hold `mem_wr_done`=1 until `mem_wr`=0 is sampled, then go to `IDLE`.
- A new request is accepted only in `IDLE`, so a back-to-back request is accepted one cycle after the prior handshake closes.
- Read-after-write to the same index returns the new data, because the array write completes before `IDLE` is re-entered.

## Timing
- Reset (asynchronous, `rst_n`=0):
  - State goes to `IDLE`.
  - `mem_wr_done`=0, `data_in_bus_lv2_mem`=0, data bus `'z`, `proto_err`=0.
  - The array is cleared to 0.
- Reset mid-operation drops a pending read, and drops a pending write that has not yet reached the array.
- Read: request is sampled at edge N. `data_in_bus_lv2_mem`=1 and data are valid after edge N+`RD_LATENCY`, and are held until the edge where `mem_rd`=0 is sampled.
- Write: address and data are captured at edge N. The array is updated and `mem_wr_done`=1 after edge N+`WR_LATENCY`, held until the edge where `mem_wr`=0 is sampled.
- `mem_wr_done` and `data_in_bus_lv2_mem` are never high together.
- The bus is driven for exactly the cycles in which `data_in_bus_lv2_mem`=1.

## Configuration
- `MEM_PROT_CHK_EN` defined: the `proto_err` port exists and is set (sticky until reset) by any of the following:
  - `mem_rd` and `mem_wr` both high in `IDLE`.
  - `mem_rd` dropped in `RD_WAIT`.
  - `mem_wr` asserted while in a read state.
  - `mem_rd` asserted while in a write state.
- `MEM_PROT_CHK_EN` undefined:
  - No `proto_err` port.
  - Same FSM behaviour: simultaneous requests are ignored and an early `mem_rd` drop aborts.

## Test plan
- Reset then read address 0x10: with `RD_LATENCY`=4, `data_in_bus_lv2_mem` rises 4 cycles after the request edge, bus reads 0x00000000, and both return to idle one cycle after `mem_rd` drops.
- Write 0xDEADBEEF to address 0x20 then read 0x20: `mem_wr_done` rises 2 cycles after the request; the read returns 0xDEADBEEF.
- Write 0x12345678 to address 0x5 then read address 0x405 (wrap, `MEM_DEPTH`=1024): the read returns 0x12345678.
- Assert `mem_rd` and `mem_wr` together: there is no response on either handshake, and `proto_err`=1 with the macro defined.
- Drop `mem_rd` after 2 cycles of `RD_WAIT`: the bus stays `'z` and `data_in_bus_lv2_mem` stays 0; a following read of another address works normally.
- Pulse `rst_n` low during `WR_WAIT` of 0xCAFEF00D to address 0x30: outputs clear immediately; a later read of 0x30 returns 0x00000000.
